// File: rtl/btn_pulse_gen.sv
// Push-button conditioner: per-channel 2-flop sync, debounce, and a one-cycle press pulse on bto.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses (REPEAT_DELAY, then every REPEAT_PERIOD).
module btn_pulse_gen #(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] bto,
   output logic [N_BTN-1:0] btn_level
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW = $clog2(RMAX + 1);
   localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rep_state_t;
`endif

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      logic          sync1;
      logic          sync2;
      logic          level;
      logic          level_d;
      logic          pulse;
      logic [CW-1:0] cnt;
      logic          press;

      assign press = level & ~level_d;

      // cnt only advances while the synchronized input disagrees with the accepted level
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
         end else begin
            sync1   <= btn_raw[i];
            sync2   <= sync1;
            level_d <= level;
            if (sync2 == level) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               level <= sync2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end

`ifdef BTN_AUTOREPEAT_EN
      rep_state_t    state;
      logic [RW-1:0] rcnt;
      logic          fall_now;

      // level is about to drop on this edge; used to cancel a due repeat pulse
      assign fall_now = level & ~sync2 & (cnt == CNT_LAST);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state <= IDLE;
            rcnt  <= '0;
            pulse <= 1'b0;
         end else begin
            pulse <= 1'b0;
            if (fall_now) begin
               state <= IDLE;
               rcnt  <= '0;
            end else begin
               case (state)
                  IDLE: begin
                     if (press) begin
                        state <= DELAY;
                        rcnt  <= '0;
                        pulse <= 1'b1;
                     end
                  end
                  DELAY: begin
                     if (rcnt == RD_LAST) begin
                        state <= REPEAT;
                        rcnt  <= '0;
                        pulse <= 1'b1;
                     end else begin
                        rcnt <= rcnt + RW'(1);
                     end
                  end
                  REPEAT: begin
                     if (rcnt == RP_LAST) begin
                        rcnt  <= '0;
                        pulse <= 1'b1;
                     end else begin
                        rcnt <= rcnt + RW'(1);
                     end
                  end
                  default: begin
                     state <= IDLE;
                     rcnt  <= '0;
                  end
               endcase
            end
         end
      end
`else
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pulse <= 1'b0;
         end else begin
            pulse <= press;
         end
      end
`endif

      assign bto[i]       = pulse;
      assign btn_level[i] = level;
   end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Bench for btn_pulse_gen: per-scenario tasks compared each cycle against a sample-window reference model.
module tb_btn_pulse_gen;

   localparam int N    = 4;
   localparam int D    = 4;
   localparam int RD   = 10;
   localparam int RP   = 5;
   localparam int HIST = 4096;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] btn_raw = '0;
   logic [N-1:0] bto;
   logic [N-1:0] btn_level;

   int n_cmp = 0;
   int n_fail = 0;

   btn_pulse_gen #(
      .N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .bto(bto), .btn_level(btn_level)
   );

   always #5 clk = ~clk;

   // Reference model: a level flips once the last D synchronized samples all disagree with it
   // and D edges have passed since the previous flip; pulses follow the rise by one edge.
   logic [N-1:0] hist [0:HIST-1];
   int           m_n;
   logic [N-1:0] m_level, m_bto, m_rise_prev, m_active;
   int           m_last_flip [N];
   int           m_press_edge [N];
   logic         mf, ms, mnb, mrise, mfall;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n = 0;
         m_level = '0;
         m_bto = '0;
         m_rise_prev = '0;
         m_active = '0;
         for (int ch = 0; ch < N; ch++) begin
            m_last_flip[ch] = 0;
            m_press_edge[ch] = 0;
         end
      end else begin
         m_n = m_n + 1;
         if (m_n < HIST) hist[m_n] = btn_raw;
         for (int ch = 0; ch < N; ch++) begin
            mnb = m_rise_prev[ch];
            mf = 1'b0;
            if (m_n - m_last_flip[ch] >= D) begin
               mf = 1'b1;
               for (int k = m_n - 1 - D; k <= m_n - 2; k++) begin
                  ms = (k >= 1) ? hist[k][ch] : 1'b0;
                  if (ms == m_level[ch]) mf = 1'b0;
               end
            end
            mrise = mf & ~m_level[ch];
            mfall = mf & m_level[ch];
`ifdef BTN_AUTOREPEAT_EN
            if (m_rise_prev[ch]) begin
               m_active[ch] = 1'b1;
               m_press_edge[ch] = m_n;
            end else if (m_active[ch]) begin
               if (mfall) m_active[ch] = 1'b0;
               else if ((m_n - m_press_edge[ch] >= RD) && ((m_n - m_press_edge[ch] - RD) % RP == 0))
                  mnb = 1'b1;
            end
`else
            if (mfall) m_active[ch] = 1'b0;
`endif
            if (mf) begin
               m_level[ch] = ~m_level[ch];
               m_last_flip[ch] = m_n;
            end
            m_rise_prev[ch] = mrise;
            m_bto[ch] = mnb;
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      btn_raw = '0;
      repeat (3) begin
         @(negedge clk);
         n_cmp++; if (bto !== '0) begin n_fail++; $display("FAIL reset_bto: got %b want 0", bto); end
         n_cmp++; if (btn_level !== '0) begin n_fail++; $display("FAIL reset_level: got %b want 0", btn_level); end
      end
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         n_cmp++; if (bto !== m_bto) begin n_fail++; $display("FAIL reset_run_bto: got %b want %b edge %0d", bto, m_bto, m_n); end
         n_cmp++; if (btn_level !== m_level) begin n_fail++; $display("FAIL reset_run_level: got %b want %b edge %0d", btn_level, m_level, m_n); end
      end
   endtask

   task automatic test_clean_press();
      int e0, pe, le, cnt3, cnt_other, exp_cnt;
      e0 = m_n + 1; pe = -1; le = -1; cnt3 = 0; cnt_other = 0;
      btn_raw[3] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         n_cmp++; if (bto !== m_bto) begin n_fail++; $display("FAIL clean_bto: got %b want %b edge %0d", bto, m_bto, m_n); end
         n_cmp++; if (btn_level !== m_level) begin n_fail++; $display("FAIL clean_level: got %b want %b edge %0d", btn_level, m_level, m_n); end
         if (bto[3]) begin cnt3++; if (pe < 0) pe = m_n; end
         if (btn_level[3] && le < 0) le = m_n;
         if (bto[2:0] != 3'b000) cnt_other++;
      end
`ifdef BTN_AUTOREPEAT_EN
      exp_cnt = 2;
`else
      exp_cnt = 1;
`endif
      n_cmp++; if (le !== e0 + 5) begin n_fail++; $display("FAIL clean_level_edge: got %0d want %0d", le, e0 + 5); end
      n_cmp++; if (pe !== e0 + 6) begin n_fail++; $display("FAIL clean_pulse_edge: got %0d want %0d", pe, e0 + 6); end
      n_cmp++; if (cnt3 !== exp_cnt) begin n_fail++; $display("FAIL clean_pulse_count: got %0d want %0d", cnt3, exp_cnt); end
      n_cmp++; if (cnt_other !== 0) begin n_fail++; $display("FAIL clean_other_bits: got %0d want 0", cnt_other); end
      btn_raw[3] = 1'b0;
      repeat (14) begin
         @(negedge clk);
         n_cmp++; if (bto !== m_bto) begin n_fail++; $display("FAIL clean_rel_bto: got %b want %b edge %0d", bto, m_bto, m_n); end
         n_cmp++; if (btn_level !== m_level) begin n_fail++; $display("FAIL clean_rel_level: got %b want %b edge %0d", btn_level, m_level, m_n); end
      end
   endtask

   task automatic test_bounce();
      int f, pe, cnt_b, cnt0, len;
      cnt_b = 0; cnt0 = 0; pe = -1;
      for (int ph = 0; ph < 4; ph++) begin
         btn_raw[0] = (ph % 2 == 0) ? 1'b1 : 1'b0;
         len = (ph == 0) ? 3 : int'($urandom_range(1, 3));
         for (int c = 0; c < len; c++) begin
            @(negedge clk);
            n_cmp++; if (bto !== m_bto) begin n_fail++; $display("FAIL bounce_bto: got %b want %b edge %0d", bto, m_bto, m_n); end
            n_cmp++; if (btn_level !== m_level) begin n_fail++; $display("FAIL bounce_level: got %b want %b edge %0d", btn_level, m_level, m_n); end
            if (bto[0] || btn_level[0]) cnt_b++;
         end
      end
      f = m_n + 1;
      btn_raw[0] = 1'b1;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         n_cmp++; if (bto !== m_bto) begin n_fail++; $display("FAIL bounce_hold_bto: got %b want %b edge %0d", bto, m_bto, m_n); end
         n_cmp++; if (btn_level !== m_level) begin n_fail++; $display("FAIL bounce_hold_level: got %b want %b edge %0d", btn_level, m_level, m_n); end
         if (bto[0] || (pe < 0 && btn_level[0] && m_n < f + 4)) begin cnt0++; if (pe < 0) pe = m_n; end
      end
      n_cmp++; if (cnt_b !== 0) begin n_fail++; $display("FAIL bounce_glitch_activity: got %0d want 0", cnt_b); end
      n_cmp++; if (pe !== f + 6) begin n_fail++; $display("FAIL bounce_pulse_edge: got %0d want %0d", pe, f + 6); end
      n_cmp++; if (cnt0 !== 1) begin n_fail++; $display("FAIL bounce_pulse_count: got %0d want 1", cnt0); end
      btn_raw[0] = 1'b0;
      repeat (14) begin
         @(negedge clk);
         n_cmp++; if (bto !== m_bto) begin n_fail++; $display("FAIL bounce_rel_bto: got %b want %b edge %0d", bto, m_bto, m_n); end
         n_cmp++; if (btn_level !== m_level) begin n_fail++; $display("FAIL bounce_rel_level: got %b want %b edge %0d", btn_level, m_level, m_n); end
      end
   endtask

   task automatic test_simultaneous();
      int e0, r, hold, pe1, pe2, fe1, fe2, late;
      hold = int'($urandom_range(10, 25));
      e0 = m_n + 1; pe1 = -1; pe2 = -1; fe1 = -1; fe2 = -1; late = 0;
      btn_raw[2:1] = 2'b11;
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         n_cmp++; if (bto !== m_bto) begin n_fail++; $display("FAIL simul_bto: got %b want %b edge %0d", bto, m_bto, m_n); end
         n_cmp++; if (btn_level !== m_level) begin n_fail++; $display("FAIL simul_level: got %b want %b edge %0d", btn_level, m_level, m_n); end
         if (bto[1] && pe1 < 0) pe1 = m_n;
         if (bto[2] && pe2 < 0) pe2 = m_n;
      end
      n_cmp++; if (pe1 !== e0 + 6) begin n_fail++; $display("FAIL simul_pulse1_edge: got %0d want %0d", pe1, e0 + 6); end
      n_cmp++; if (pe2 !== e0 + 6) begin n_fail++; $display("FAIL simul_pulse2_edge: got %0d want %0d", pe2, e0 + 6); end
      r = m_n + 1;
      btn_raw[2:1] = 2'b00;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         n_cmp++; if (bto !== m_bto) begin n_fail++; $display("FAIL simul_rel_bto: got %b want %b edge %0d", bto, m_bto, m_n); end
         n_cmp++; if (btn_level !== m_level) begin n_fail++; $display("FAIL simul_rel_level: got %b want %b edge %0d", btn_level, m_level, m_n); end
         if (!btn_level[1] && fe1 < 0) fe1 = m_n;
         if (!btn_level[2] && fe2 < 0) fe2 = m_n;
         if ((bto[1] && !btn_level[1]) || (bto[2] && !btn_level[2])) late++;
      end
      n_cmp++; if (fe1 !== r + 5) begin n_fail++; $display("FAIL simul_fall1_edge: got %0d want %0d", fe1, r + 5); end
      n_cmp++; if (fe2 !== r + 5) begin n_fail++; $display("FAIL simul_fall2_edge: got %0d want %0d", fe2, r + 5); end
      n_cmp++; if (late !== 0) begin n_fail++; $display("FAIL simul_release_pulse: got %0d want 0", late); end
   endtask

   task automatic test_autorepeat();
      int e0, hold, p, fe, cnt3, exp_cnt;
      hold = int'($urandom_range(40, 55));
      e0 = m_n + 1; cnt3 = 0;
      btn_raw[3] = 1'b1;
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         n_cmp++; if (bto !== m_bto) begin n_fail++; $display("FAIL repeat_bto: got %b want %b edge %0d", bto, m_bto, m_n); end
         n_cmp++; if (btn_level !== m_level) begin n_fail++; $display("FAIL repeat_level: got %b want %b edge %0d", btn_level, m_level, m_n); end
         if (bto[3]) cnt3++;
      end
      btn_raw[3] = 1'b0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         n_cmp++; if (bto !== m_bto) begin n_fail++; $display("FAIL repeat_rel_bto: got %b want %b edge %0d", bto, m_bto, m_n); end
         n_cmp++; if (btn_level !== m_level) begin n_fail++; $display("FAIL repeat_rel_level: got %b want %b edge %0d", btn_level, m_level, m_n); end
         if (bto[3]) cnt3++;
      end
      p = e0 + 6;
      fe = e0 + hold + 5;
      exp_cnt = 1;
`ifdef BTN_AUTOREPEAT_EN
      for (int t = p + RD; t < fe; t += RP) exp_cnt++;
`endif
      n_cmp++; if (cnt3 !== exp_cnt) begin n_fail++; $display("FAIL repeat_pulse_count: got %0d want %0d (hold %0d)", cnt3, exp_cnt, hold); end
   endtask

   task automatic test_random();
      int run [N];
      for (int ch = 0; ch < N; ch++) run[ch] = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         n_cmp++; if (bto !== m_bto) begin n_fail++; $display("FAIL random_bto: got %b want %b edge %0d", bto, m_bto, m_n); end
         n_cmp++; if (btn_level !== m_level) begin n_fail++; $display("FAIL random_level: got %b want %b edge %0d", btn_level, m_level, m_n); end
         for (int ch = 0; ch < N; ch++) begin
            if (run[ch] == 0) begin
               btn_raw[ch] = 1'($urandom_range(0, 1));
               run[ch] = int'($urandom_range(1, 12));
            end
            run[ch]--;
         end
      end
      btn_raw = '0;
      repeat (20) begin
         @(negedge clk);
         n_cmp++; if (bto !== m_bto) begin n_fail++; $display("FAIL random_rel_bto: got %b want %b edge %0d", bto, m_bto, m_n); end
         n_cmp++; if (btn_level !== m_level) begin n_fail++; $display("FAIL random_rel_level: got %b want %b edge %0d", btn_level, m_level, m_n); end
      end
   endtask

   task automatic test_async_reset();
      int pe;
      pe = -1;
      btn_raw[3] = 1'b1;
      repeat (10) begin
         @(negedge clk);
         n_cmp++; if (bto !== m_bto) begin n_fail++; $display("FAIL areset_pre_bto: got %b want %b edge %0d", bto, m_bto, m_n); end
         n_cmp++; if (btn_level !== m_level) begin n_fail++; $display("FAIL areset_pre_level: got %b want %b edge %0d", btn_level, m_level, m_n); end
      end
      n_cmp++; if (btn_level[3] !== 1'b1) begin n_fail++; $display("FAIL areset_held_level: got %b want 1", btn_level[3]); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (bto !== '0) begin n_fail++; $display("FAIL areset_bto: got %b want 0", bto); end
      n_cmp++; if (btn_level !== '0) begin n_fail++; $display("FAIL areset_level: got %b want 0", btn_level); end
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if ((bto | btn_level) !== '0) begin n_fail++; $display("FAIL areset_hold: got %b/%b want 0", bto, btn_level); end
      #2 rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         n_cmp++; if (bto !== m_bto) begin n_fail++; $display("FAIL areset_post_bto: got %b want %b edge %0d", bto, m_bto, m_n); end
         n_cmp++; if (btn_level !== m_level) begin n_fail++; $display("FAIL areset_post_level: got %b want %b edge %0d", btn_level, m_level, m_n); end
         if (bto[3] && pe < 0) pe = m_n;
      end
      // first edge after release samples the held button, so the press pulse follows edge 1+6
      n_cmp++; if (pe !== 7) begin n_fail++; $display("FAIL areset_repress_edge: got %0d want 7", pe); end
      btn_raw = '0;
      repeat (14) begin
         @(negedge clk);
         n_cmp++; if (bto !== m_bto) begin n_fail++; $display("FAIL areset_rel_bto: got %b want %b edge %0d", bto, m_bto, m_n); end
         n_cmp++; if (btn_level !== m_level) begin n_fail++; $display("FAIL areset_rel_level: got %b want %b edge %0d", btn_level, m_level, m_n); end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_simultaneous();
      test_autorepeat();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
